led_pattern_seq: RTL and testbench
==================================

Name: led_pattern_seq

Overview:
- Parametrised LED pattern sequencer and registered data pass-through.
- Steps through a writable pattern table at a programmable tick rate, in loop, ping-pong or one-shot mode.
- Also provides NCH independent registered data channels with valid.
- Sits between board LEDs/debug ports and the core, as the next-generation blinker/probe block.

Parameters:
- LED_W, 4, LED output width and pattern entry width.
- NUM_PAT, 6, pattern table depth (>=1); IDX_W = max(1, clog2(NUM_PAT)).
- DIV_W, 32, divider counter and period width.
- DIV_RST, 10000000, divider period loaded at reset (clk cycles per tick).
- DATA_W, 32, width of each data channel.
- NCH, 2, number of data channels (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mode  in  2  0=loop, 1=ping-pong, 2=one-shot, 3=treated as loop; sampled only on start
- start  in  1  single-cycle pulse: (re)start sequence at index 0
- stop  in  1  single-cycle pulse: return to IDLE, LEDs hold last value
- div_load  in  1  load div_val into the period register
- div_val  in  DIV_W  new period in clk cycles; 0 is treated as 1
- pat_we  in  1  pattern table write enable
- pat_addr  in  IDX_W  table write address; addresses >= NUM_PAT are ignored
- pat_data  in  LED_W  table write data
- led  out  LED_W  registered current pattern
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a one-shot sequence completes
- in_data  in  NCH*DATA_W  channel inputs, channel k at bits [k*DATA_W +: DATA_W]
- in_valid  in  NCH  per-channel valid
- out_data  out  NCH*DATA_W  registered channel outputs
- out_valid  out  NCH  registered per-channel valid

Behaviour:
Reset (async, high):
- state=IDLE; idx=0; dir=up; cnt=0; period=DIV_RST; led=0; busy=0; done=0; out_data=0; out_valid=0.
- Table reset contents, entries 0..5: 0000, 0101, 1010, 0101, 1100, 0011, LSB-aligned.
- Entries beyond 5 reset to 0. If LED_W>4, entries are zero-extended; if LED_W<4, entries are truncated.
- Reset mid-run aborts immediately; no done pulse.

States:
- IDLE:
  - start -> RUN. Latch mode, idx=0, dir=up, cnt=0, led<=table[0] on the same edge.
- RUN:
  - cnt counts 0..period-1. The tick fires on the cycle where cnt==period-1; cnt then wraps to 0.
  - On tick, next idx depends on mode:
    - loop: idx+1, wrapping NUM_PAT-1 -> 0.
    - ping-pong: reverse direction at 0 and NUM_PAT-1, with no repeat of the end entries. Example for NUM_PAT=6: 0,1,2,3,4,5,4,...,1,0,1. NUM_PAT=1 stays at 0.
    - one-shot: at NUM_PAT-1, go to DONE instead of advancing.
  - led<=table[next idx] on the tick edge, so LED latency is 0 cycles after the tick edge.
  - start: restart exactly as from IDLE. stop -> IDLE.
- DONE:
  - busy=0 and done=1 for exactly this one cycle, led held, then -> IDLE.

Simultaneous events:
- start beats stop.
- stop beats tick.
- reset beats all.

Period:
- div_load writes period (0 -> 1) and clears cnt to 0 in any state.
- In RUN, the next tick occurs period cycles after the load.
- div_load with start: both apply.

Table:
- A write takes effect the next cycle.
- led updates only on start or tick, so writing the displayed index does not change led until the next tick.

busy:
- 1 exactly while in RUN.

Data channels (each channel independent, latency 1):
- out_valid[k] <= in_valid[k].
- If in_valid[k], out_data[k] <= in_data[k]; otherwise out_data[k] holds.
- No backpressure.

Test Plan:
- Reset, then div_load div_val=4, start with mode=0 -> led=0000 at start edge; then 0101, 1010, 0101, 1100, 0011, 0000 every 4 cycles; busy=1.
- mode=1, period=1 (div_val=0), NUM_PAT=6 -> led indices 0,1,2,3,4,5,4,3,2,1,0,1 on consecutive cycles.
- mode=2, period=2 -> six patterns shown, then done=1 for exactly one cycle, busy=0, led holds 0011, then state IDLE.
- Write table[2]=1111 while idx=2 is displayed -> led unchanged until the next tick; on the next pass through idx 2, led=1111. A write to pat_addr=7 (NUM_PAT=6) has no effect.
- Channel 0: in_data=0xDEADBEEF, in_valid=01 -> next cycle out_data[31:0]=0xDEADBEEF, out_valid=01. Channel 1 holds 0. Dropping valid holds the data and clears out_valid.
- Assert reset mid-run at idx=3 -> immediately led=0, busy=0, out_valid=0, done=0; after release, start resumes from idx 0 with period=DIV_RST.

Source files
------------

// File: rtl/led_pattern_seq_if.sv
// Bundle of sequencer control, pattern-table write, LED status and data-channel signals.
// The master drives the controls and channel inputs. The slave (the sequencer) drives LEDs and channel outputs.
interface led_pattern_seq_if #(
    parameter int LED_W   = 4,
    parameter int NUM_PAT = 6,
    parameter int DIV_W   = 32,
    parameter int DATA_W  = 32,
    parameter int NCH     = 2
);
    localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

    logic [1:0]            mode;
    logic                  start;
    logic                  stop;
    logic                  div_load;
    logic [DIV_W-1:0]      div_val;
    logic                  pat_we;
    logic [IDX_W-1:0]      pat_addr;
    logic [LED_W-1:0]      pat_data;
    logic [LED_W-1:0]      led;
    logic                  busy;
    logic                  done;
    logic [NCH*DATA_W-1:0] in_data;
    logic [NCH-1:0]        in_valid;
    logic [NCH*DATA_W-1:0] out_data;
    logic [NCH-1:0]        out_valid;

    modport master (
        output mode, start, stop, div_load, div_val, pat_we, pat_addr, pat_data,
        output in_data, in_valid,
        input  led, busy, done, out_data, out_valid
    );

    modport slave (
        input  mode, start, stop, div_load, div_val, pat_we, pat_addr, pat_data,
        input  in_data, in_valid,
        output led, busy, done, out_data, out_valid
    );
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer that steps through a writable table in loop, ping-pong or one-shot mode.
// The block also carries NCH independent registered data channels with valid.
module led_pattern_seq #(
    parameter int LED_W   = 4,
    parameter int NUM_PAT = 6,
    parameter int DIV_W   = 32,
    parameter int DIV_RST = 10000000,
    parameter int DATA_W  = 32,
    parameter int NCH     = 2
) (
    input logic clk,
    input logic reset,
    led_pattern_seq_if.slave bus
);
    localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAT - 1);
    localparam logic [IDX_W:0] NUM_PAT_EXT = (IDX_W + 1)'(NUM_PAT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  dir_up_q, dir_up_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [DIV_W-1:0]      period_q, period_d;
    logic [LED_W-1:0]      led_q, led_d;
    logic [LED_W-1:0]      pat_tbl [NUM_PAT];
    logic [NCH*DATA_W-1:0] out_data_q;
    logic [NCH-1:0]        out_valid_q;

    logic                  tick;
    logic [IDX_W-1:0]      adv_idx;
    logic                  adv_dir;
    logic                  adv_end;

    // Power-on table contents are 4-bit patterns, zero-extended or truncated to LED_W.
    function automatic logic [LED_W-1:0] reset_entry(int i);
        logic [3:0] v;
        case (i)
            0:       v = 4'b0000;
            1:       v = 4'b0101;
            2:       v = 4'b1010;
            3:       v = 4'b0101;
            4:       v = 4'b1100;
            5:       v = 4'b0011;
            default: v = 4'b0000;
        endcase
        return LED_W'(v);
    endfunction

    assign tick = (state_q == RUN) && (cnt_q == period_q - DIV_W'(1));

    // Next index on a tick. Ping-pong turns around at the ends without repeating the end entries.
    always_comb begin
        adv_idx = idx_q;
        adv_dir = dir_up_q;
        adv_end = 1'b0;
        case (mode_q)
            2'd1: begin
                if (NUM_PAT == 1) begin
                    adv_idx = '0;
                end else if (dir_up_q) begin
                    if (idx_q == LAST_IDX) begin
                        adv_idx = idx_q - 1'b1;
                        adv_dir = 1'b0;
                    end else begin
                        adv_idx = idx_q + 1'b1;
                    end
                end else begin
                    if (idx_q == '0) begin
                        adv_idx = IDX_W'(1);
                        adv_dir = 1'b1;
                    end else begin
                        adv_idx = idx_q - 1'b1;
                    end
                end
            end
            2'd2: begin
                if (idx_q == LAST_IDX) begin
                    adv_end = 1'b1;
                end else begin
                    adv_idx = idx_q + 1'b1;
                end
            end
            default: begin
                adv_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
        endcase
    end

    // Event priority is start, then stop, then tick. A divider load is applied on top of any of them.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        led_d    = led_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    mode_d   = bus.mode;
                    idx_d    = '0;
                    dir_up_d = 1'b1;
                    cnt_d    = '0;
                    led_d    = pat_tbl[0];
                end
            end
            RUN: begin
                if (bus.start) begin
                    mode_d   = bus.mode;
                    idx_d    = '0;
                    dir_up_d = 1'b1;
                    cnt_d    = '0;
                    led_d    = pat_tbl[0];
                end else if (bus.stop) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
                    if (tick) begin
                        if (adv_end) begin
                            state_d = DONE;
                        end else begin
                            idx_d    = adv_idx;
                            dir_up_d = adv_dir;
                            led_d    = pat_tbl[adv_idx];
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.div_load) begin
            period_d = (bus.div_val == '0) ? DIV_W'(1) : bus.div_val;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mode_q   <= 2'd0;
            idx_q    <= '0;
            dir_up_q <= 1'b1;
            cnt_q    <= '0;
            period_q <= DIV_W'(DIV_RST);
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            led_q    <= led_d;
        end
    end

    // Writes to addresses past the end of the table are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PAT; i++) begin
                pat_tbl[i] <= reset_entry(i);
            end
        end else if (bus.pat_we && ({1'b0, bus.pat_addr} < NUM_PAT_EXT)) begin
            pat_tbl[bus.pat_addr] <= bus.pat_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            for (int k = 0; k < NCH; k++) begin
                if (bus.in_valid[k]) begin
                    out_data_q[k*DATA_W +: DATA_W] <= bus.in_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign bus.led       = led_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq. Expected outputs are queued when stimulus is driven and compared after the next edge.
module tb_led_pattern_seq;
    localparam int LED_W   = 4;
    localparam int NUM_PAT = 6;
    localparam int DIV_W   = 32;
    localparam int DIV_RST = 20;
    localparam int DATA_W  = 32;
    localparam int NCH     = 2;

    localparam int SEL_LED   = 0;
    localparam int SEL_BUSY  = 1;
    localparam int SEL_DONE  = 2;
    localparam int SEL_DATA  = 3;
    localparam int SEL_VALID = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    exp_t       sb [$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] tbl [6];
    logic [3:0] shown;
    int         idx;
    int         pp [12] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};

    led_pattern_seq_if #(
        .LED_W(LED_W), .NUM_PAT(NUM_PAT), .DIV_W(DIV_W), .DATA_W(DATA_W), .NCH(NCH)
    ) bus ();

    led_pattern_seq #(
        .LED_W(LED_W), .NUM_PAT(NUM_PAT), .DIV_W(DIV_W), .DIV_RST(DIV_RST),
        .DATA_W(DATA_W), .NCH(NCH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic expectOut(input string tag, input int sel, input logic [63:0] val);
        sb.push_back('{tag, sel, val});
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            SEL_LED:   return 64'(bus.led);
            SEL_BUSY:  return 64'(bus.busy);
            SEL_DONE:  return 64'(bus.done);
            SEL_DATA:  return 64'(bus.out_data);
            default:   return 64'(bus.out_valid);
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.tag, observe(e.sel), e.val);
        end
    endtask

    // One clock edge. Single-cycle pulses are cleared after the edge, and then the queued expectations are checked.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.div_load = 1'b0;
        bus.pat_we   = 1'b0;
        drain();
    endtask

    task automatic resetTable();
        tbl[0] = 4'b0000; tbl[1] = 4'b0101; tbl[2] = 4'b1010;
        tbl[3] = 4'b0101; tbl[4] = 4'b1100; tbl[5] = 4'b0011;
    endtask

    initial begin
        resetTable();
        reset        = 1'b1;
        bus.mode     = 2'd0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.div_load = 1'b0;
        bus.div_val  = '0;
        bus.pat_we   = 1'b0;
        bus.pat_addr = '0;
        bus.pat_data = '0;
        bus.in_data  = '0;
        bus.in_valid = '0;
        repeat (2) @(negedge clk);
        expectOut("rst_led", SEL_LED, 64'd0);
        expectOut("rst_busy", SEL_BUSY, 64'd0);
        expectOut("rst_done", SEL_DONE, 64'd0);
        expectOut("rst_valid", SEL_VALID, 64'd0);
        expectOut("rst_data", SEL_DATA, 64'd0);
        drain();
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] loop mode, period 4, table writes");
        bus.div_load = 1'b1; bus.div_val = 32'd4; bus.mode = 2'd0; bus.start = 1'b1;
        expectOut("loop_start_led", SEL_LED, 64'(tbl[0]));
        expectOut("loop_busy", SEL_BUSY, 64'd1);
        applyStimulus();
        idx   = 0;
        shown = tbl[0];
        for (int k = 1; k <= 14; k++) begin
            for (int c = 1; c <= 4; c++) begin
                if (k == 9 && c == 1) begin
                    bus.pat_we = 1'b1; bus.pat_addr = 3'd2; bus.pat_data = 4'b1111;
                    tbl[2] = 4'b1111;
                end
                if (k == 9 && c == 2) begin
                    bus.pat_we = 1'b1; bus.pat_addr = 3'd7; bus.pat_data = 4'b1111;
                end
                if (c == 4) begin
                    idx   = (idx + 1) % NUM_PAT;
                    shown = tbl[idx];
                end
                expectOut($sformatf("loop_led_k%0d_c%0d", k, c), SEL_LED, 64'(shown));
                applyStimulus();
            end
        end
        expectOut("loop_busy_late", SEL_BUSY, 64'd1);
        drain();

        $display("[TB] ping-pong, period from div_val 0");
        bus.div_load = 1'b1; bus.div_val = 32'd0; bus.mode = 2'd1; bus.start = 1'b1;
        expectOut("pp_led_0", SEL_LED, 64'(tbl[0]));
        applyStimulus();
        for (int i = 1; i < 12; i++) begin
            expectOut($sformatf("pp_led_%0d", i), SEL_LED, 64'(tbl[pp[i]]));
            applyStimulus();
        end
        bus.stop = 1'b1;
        expectOut("pp_stop_busy", SEL_BUSY, 64'd0);
        expectOut("pp_stop_led", SEL_LED, 64'(tbl[1]));
        applyStimulus();
        expectOut("idle_led_hold", SEL_LED, 64'(tbl[1]));
        applyStimulus();

        $display("[TB] one-shot, period 2");
        bus.div_load = 1'b1; bus.div_val = 32'd2; bus.mode = 2'd2; bus.start = 1'b1;
        expectOut("os_led_0", SEL_LED, 64'(tbl[0]));
        expectOut("os_busy_0", SEL_BUSY, 64'd1);
        applyStimulus();
        for (int p = 1; p < NUM_PAT; p++) begin
            expectOut($sformatf("os_hold_%0d", p), SEL_LED, 64'(tbl[p-1]));
            applyStimulus();
            expectOut($sformatf("os_led_%0d", p), SEL_LED, 64'(tbl[p]));
            expectOut($sformatf("os_nodone_%0d", p), SEL_DONE, 64'd0);
            applyStimulus();
        end
        expectOut("os_last_busy", SEL_BUSY, 64'd1);
        applyStimulus();
        expectOut("os_done", SEL_DONE, 64'd1);
        expectOut("os_done_busy", SEL_BUSY, 64'd0);
        expectOut("os_done_led", SEL_LED, 64'h3);
        applyStimulus();
        expectOut("os_after_done", SEL_DONE, 64'd0);
        expectOut("os_after_busy", SEL_BUSY, 64'd0);
        expectOut("os_after_led", SEL_LED, 64'h3);
        applyStimulus();

        $display("[TB] data channels");
        bus.in_data = {32'h12345678, 32'hDEADBEEF}; bus.in_valid = 2'b01;
        expectOut("ch_data_a", SEL_DATA, {32'h0, 32'hDEADBEEF});
        expectOut("ch_valid_a", SEL_VALID, 64'h1);
        applyStimulus();
        bus.in_data = '0; bus.in_valid = 2'b00;
        expectOut("ch_data_hold", SEL_DATA, {32'h0, 32'hDEADBEEF});
        expectOut("ch_valid_drop", SEL_VALID, 64'h0);
        applyStimulus();
        bus.in_data = {32'hCAFEF00D, 32'h0}; bus.in_valid = 2'b10;
        expectOut("ch_data_b", SEL_DATA, {32'hCAFEF00D, 32'hDEADBEEF});
        expectOut("ch_valid_b", SEL_VALID, 64'h2);
        applyStimulus();

        $display("[TB] reset mid-run");
        bus.in_data = {32'hAAAA5555, 32'h5555AAAA}; bus.in_valid = 2'b11;
        bus.div_load = 1'b1; bus.div_val = 32'd4; bus.mode = 2'd0; bus.start = 1'b1;
        expectOut("mr_start_led", SEL_LED, 64'(tbl[0]));
        applyStimulus();
        idx   = 0;
        shown = tbl[0];
        for (int k = 1; k <= 3; k++) begin
            for (int c = 1; c <= 4; c++) begin
                if (c == 4) begin
                    idx   = idx + 1;
                    shown = tbl[idx];
                end
                expectOut($sformatf("mr_led_k%0d_c%0d", k, c), SEL_LED, 64'(shown));
                applyStimulus();
            end
        end
        expectOut("mr_valid_pre", SEL_VALID, 64'h3);
        drain();
        reset = 1'b1;
        #1;
        expectOut("mr_rst_led", SEL_LED, 64'd0);
        expectOut("mr_rst_busy", SEL_BUSY, 64'd0);
        expectOut("mr_rst_done", SEL_DONE, 64'd0);
        expectOut("mr_rst_valid", SEL_VALID, 64'd0);
        expectOut("mr_rst_data", SEL_DATA, 64'd0);
        drain();
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 2'b00;
        resetTable();
        @(negedge clk);
        bus.mode = 2'd0; bus.start = 1'b1;
        expectOut("rs_start_led", SEL_LED, 64'(tbl[0]));
        expectOut("rs_busy", SEL_BUSY, 64'd1);
        applyStimulus();
        for (int c = 1; c <= DIV_RST; c++) begin
            expectOut($sformatf("rs_led_c%0d", c), SEL_LED, (c == DIV_RST) ? 64'(tbl[1]) : 64'(tbl[0]));
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
